// File: rtl/AggrCDMAPkg.sv
// Shared CDMA crossbar constants: word width, code length and the spreading-code table.
package AggrCDMAPkg;

  localparam int DATA_WIDTH      = 8;
  localparam int CDMA_CODE_WIDTH = 4;
  localparam int LOG_CODE_WIDTH  = $clog2(CDMA_CODE_WIDTH);
  localparam int COUNTER_WIDTH   = LOG_CODE_WIDTH;

  localparam logic [CDMA_CODE_WIDTH-1:0] CDMA_CODES [CDMA_CODE_WIDTH] = '{
    4'b0110, 4'b0101, 4'b0011, 4'b1111
  };

endpackage

// File: rtl/cdma_encoder.sv
// Transmit-side CDMA spreader: one word per code frame, chips aligned to the decoders' counter/rotate_code.
// Optional build macro CDMA_ENC_STATS_EN adds frames_sent and sticky underrun outputs.
//
// state | meaning
// IDLE  | no frame on the channel, chip_out = 0
// SEND  | frame_data being spread across the current code frame
module cdma_encoder
  import AggrCDMAPkg::*;
#(
  parameter int CODE_NUM = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 rotate_code,
  input  logic [COUNTER_WIDTH-1:0]             counter,
  input  logic                                 in_valid,
  input  logic [DATA_WIDTH-1:0]                in_data,
  output logic                                 in_ready,
  output logic [DATA_WIDTH+LOG_CODE_WIDTH-1:0] chip_out,
  output logic                                 active
`ifdef CDMA_ENC_STATS_EN
  ,
  output logic [15:0]                          frames_sent,
  output logic                                 underrun
`endif
);

  localparam int CW = DATA_WIDTH + LOG_CODE_WIDTH;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                       state_q, state_d;
  logic                         hold_valid;
  logic [DATA_WIDTH-1:0]        hold_data;
  logic [DATA_WIDTH-1:0]        frame_data;
  logic [CDMA_CODE_WIDTH-1:0]   code_reg;
  logic                         last_chip, fb, accept, load_frame;
  logic [CW-1:0]                data_ext, data_neg;

  assign last_chip = &counter;
  assign fb        = last_chip & rotate_code;
  assign in_ready  = !hold_valid;
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    load_frame = 1'b0;
    case (state_q)
      IDLE: if (fb && hold_valid) begin
        state_d    = SEND;
        load_frame = 1'b1;
      end
      SEND: if (fb) begin
        if (hold_valid) load_frame = 1'b1;
        else            state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      frame_data <= '0;
      code_reg   <= CDMA_CODES[CODE_NUM];
    end else begin
      state_q <= state_d;
      // accept and load_frame are exclusive: one needs hold_valid low, the other high
      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= in_data;
      end else if (load_frame) begin
        hold_valid <= 1'b0;
      end
      if (load_frame) frame_data <= hold_data;
      if (last_chip)        code_reg <= CDMA_CODES[CODE_NUM];
      else if (rotate_code) code_reg <= {code_reg[0], code_reg[CDMA_CODE_WIDTH-1:1]};
    end
  end

  assign data_ext = {{LOG_CODE_WIDTH{1'b0}}, frame_data};
  assign data_neg = -data_ext;
  assign active   = (state_q == SEND);
  assign chip_out = !active ? '0 : (code_reg[0] ? data_neg : data_ext);

`ifdef CDMA_ENC_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frames_sent <= '0;
      underrun    <= 1'b0;
    end else if (fb && state_q == SEND) begin
      frames_sent <= frames_sent + 16'd1;
      if (!hold_valid) underrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cdma_encoder.sv
// Directed bench for cdma_encoder with code 0110, width 8, frame length 4.
module tb_cdma_encoder;
  import AggrCDMAPkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rotate_code = 1'b1;
  logic [1:0] counter = 2'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [9:0] chip_out;
  logic       active;
`ifdef CDMA_ENC_STATS_EN
  logic [15:0] frames_sent;
  logic        underrun;
`endif

  int total = 0;
  int bad   = 0;

  cdma_encoder #(.CODE_NUM(0)) dut (
    .clk(clk), .rst(rst), .rotate_code(rotate_code), .counter(counter),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .chip_out(chip_out), .active(active)
`ifdef CDMA_ENC_STATS_EN
    , .frames_sent(frames_sent), .underrun(underrun)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1 counter = counter + 2'd1;
    end
  end

  task automatic wait_counter(input logic [1:0] v);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (counter == v) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wait_counter timeout: counter=%0d required=%0d", counter, v);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || active !== 1'b0 || chip_out !== 10'h000) begin
        bad++;
        $display("FAIL reset_idle: in_ready=%b active=%b chip_out=%h required 1/0/000", in_ready, active, chip_out);
      end
    end
  endtask

  task automatic test_single;
    logic [9:0] exp [4];
    int sgn [4];
    int sum;
    exp = '{10'h05A, 10'h3A6, 10'h3A6, 10'h05A};
    sgn = '{1, -1, -1, 1};
    sum = 0;
    wait_counter(2'd1);
    in_valid = 1'b1; in_data = 8'h5A;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_counter(2'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (chip_out !== exp[i] || active !== 1'b1) begin
        bad++;
        $display("FAIL single_chip%0d: chip_out=%h active=%b required %h/1", i, chip_out, active, exp[i]);
      end
      sum = sum + sgn[i] * int'($signed(chip_out));
    end
    @(negedge clk);
    total++;
    if (active !== 1'b0 || chip_out !== 10'h000) begin
      bad++;
      $display("FAIL single_after: chip_out=%h active=%b required 000/0", chip_out, active);
    end
    total++;
    if (sum / 4 != 32'h5A) begin
      bad++;
      $display("FAIL single_decoded: got=%0d required=%0d", sum / 4, 90);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp [8];
    exp = '{10'h001, 10'h3FF, 10'h3FF, 10'h001, 10'h0FF, 10'h301, 10'h301, 10'h0FF};
    wait_counter(2'd1);
    in_valid = 1'b1; in_data = 8'h01;
    @(posedge clk); #1 in_data = 8'hFF;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ready_hold: in_ready=%b required 0", in_ready);
    end
    wait_counter(2'd0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (chip_out !== exp[i] || active !== 1'b1) begin
        bad++;
        $display("FAIL b2b_chip%0d: chip_out=%h active=%b required %h/1", i, chip_out, active, exp[i]);
      end
      if (i == 0) begin
        @(posedge clk); #1 in_valid = 1'b0;
      end
    end
    @(negedge clk);
    total++;
    if (active !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end: active=%b required 0", active);
    end
  endtask

  task automatic test_same_cycle;
    logic [9:0] exp [4];
    exp = '{10'h033, 10'h3CD, 10'h3CD, 10'h033};
    wait_counter(2'd3);
    in_valid = 1'b1; in_data = 8'h33;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (active !== 1'b0 || chip_out !== 10'h000) begin
        bad++;
        $display("FAIL same_cycle_wait%0d: active=%b chip_out=%h required 0/000", i, active, chip_out);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (chip_out !== exp[i] || active !== 1'b1) begin
        bad++;
        $display("FAIL same_cycle_chip%0d: chip_out=%h active=%b required %h/1", i, chip_out, active, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    wait_counter(2'd1);
    in_valid = 1'b1; in_data = 8'h10;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_counter(2'd0);
    total++;
    if (chip_out !== 10'h010 || active !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_pre: chip_out=%h active=%b required 010/1", chip_out, active);
    end
    in_valid = 1'b1; in_data = 8'h20;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    #1;
    total++;
    if (chip_out !== 10'h000 || active !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_async: chip_out=%h active=%b in_ready=%b required 000/0/1", chip_out, active, in_ready);
    end
    @(negedge clk); rst = 1'b1;
`ifdef CDMA_ENC_STATS_EN
    total++;
    if (frames_sent !== 16'd0 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_stats: frames_sent=%0d underrun=%b required 0/0", frames_sent, underrun);
    end
`endif
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (active !== 1'b0 || chip_out !== 10'h000) begin
        bad++;
        $display("FAIL rst_mid_after%0d: active=%b chip_out=%h required 0/000", i, active, chip_out);
      end
    end
  endtask

`ifdef CDMA_ENC_STATS_EN
  task automatic send_word(input logic [7:0] w);
    logic done;
    done = 1'b0;
    in_valid = 1'b1; in_data = w;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL send_word timeout: word=%h not accepted", w);
    end
  endtask

  task automatic test_stats;
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    repeat (14) @(negedge clk);
    total++;
    if (frames_sent !== 16'd3 || underrun !== 1'b1) begin
      bad++;
      $display("FAIL stats_gap: frames_sent=%0d underrun=%b required 3/1", frames_sent, underrun);
    end
    send_word(8'h44);
    repeat (10) @(negedge clk);
    total++;
    if (frames_sent !== 16'd4 || underrun !== 1'b1) begin
      bad++;
      $display("FAIL stats_sticky: frames_sent=%0d underrun=%b required 4/1", frames_sent, underrun);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_same_cycle;
    test_reset_mid;
`ifdef CDMA_ENC_STATS_EN
    test_stats;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdma_encoder.md
Name: cdma_encoder

Overview:
- Transmit-side counterpart of the per-code CDMA decoder in the AggrCDMAPkg crossbar.
- Accepts DATA_WIDTH words over a valid/ready handshake and spreads each word across one code frame of CDMA_CODE_WIDTH chips using CDMA_CODES[CODE_NUM].
- Each chip cycle drives a signed contribution of +data or -data. An external adder tree sums all encoders onto the shared channel bus, and the decoders despread that bus.
- Frame timing comes from the same global counter/rotate_code strobe the decoders use, so chip alignment is exact.

Parameters:
- CODE_NUM, 0: index into CDMA_CODES selecting this encoder's spreading code.
- Package constants are used, not redeclared: DATA_WIDTH, CDMA_CODE_WIDTH, LOG_CODE_WIDTH, COUNTER_WIDTH, CDMA_CODES.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- rotate_code, input, 1: chip-advance strobe, shared with the decoders.
- counter, input, COUNTER_WIDTH: global chip index within the frame. All-ones = last chip.
- in_valid, input, 1: in_data is valid.
- in_data, input, DATA_WIDTH: unsigned word to transmit.
- in_ready, output, 1: encoder can accept a word this cycle.
- chip_out, output, DATA_WIDTH+LOG_CODE_WIDTH: two's-complement chip contribution to the channel adder.
- active, output, 1: chip_out carries a frame (state SEND).

Behaviour:
- Reset (rst low, async) clears:
  - state=IDLE, hold_valid=0, frame_data=0.
  - code_reg=CDMA_CODES[CODE_NUM].
  - Outputs: in_ready=1, chip_out=0, active=0.
- Input handshake:
  - in_ready = !hold_valid.
  - A transfer occurs when in_valid & in_ready: in_data is latched into hold_data and hold_valid is set next cycle.
  - in_data is ignored when in_ready=0.
- code_reg:
  - Loads CDMA_CODES[CODE_NUM] every cycle counter==all-ones.
  - Otherwise rotates right by one when rotate_code=1: {code_reg[0], code_reg[W-1:1]}.
  - This exactly mirrors the decoder. chip = code_reg[0].
- Frame boundary event: fb = (counter==all-ones) & rotate_code.
- States and transitions on fb:
  - IDLE -> SEND if hold_valid. Then frame_data <= hold_data and hold_valid <= 0.
  - IDLE stays IDLE if !hold_valid.
  - SEND -> SEND if hold_valid, loading the next word back-to-back with no idle frame.
  - SEND -> IDLE if !hold_valid.
  - No transitions occur without fb.
  - frame_data is stable for all CDMA_CODE_WIDTH chips of a frame.
- Simultaneous accept and fb in the same cycle:
  - The word being accepted is not eligible for this fb. It waits for the next fb.
  - The move hold->frame uses the old hold_valid only.
- Output (combinational from registers only, zero latency):
  - IDLE: chip_out = 0.
  - SEND, chip=0: chip_out = zero-extended frame_data.
  - SEND, chip=1: chip_out = two's-complement negation of zero-extended frame_data, modulo 2^(DATA_WIDTH+LOG_CODE_WIDTH).
- End-to-end property: one encoder alone on the channel makes the decoder's accumulator reach CDMA_CODE_WIDTH*data. The decoder's decoded output then equals data during the counter==0 cycle following the frame.
- rotate_code=0 freezes code_reg and suppresses fb; outputs hold.
- Reset mid-frame: the frame is abandoned, the held word is dropped, and the block returns to IDLE immediately.

Optional Feature:
- Macro: CDMA_ENC_STATS_EN.
- Defined:
  - Adds output frames_sent[15:0] (reset 0).
  - Increments on each fb where state==SEND, i.e. on each completed frame. Wraps 0xFFFF->0.
  - Adds sticky output underrun (reset 0). Set on fb with state==SEND and !hold_valid, i.e. a stream gap. Cleared only by reset.
- Undefined: neither port exists and no extra logic is present.

Test Plan:
- Setup for all scenarios: DATA_WIDTH=8, CDMA_CODE_WIDTH=4, CDMA_CODES[0]=4'b0110, rotate_code=1, counter free-running.
- Reset released: in_ready=1, active=0, chip_out=0 for all counter values until the first word is accepted.
- Send 0x5A mid-frame:
  - Next frame, chip_out per counter 0..3 = 0x05A, 0x3A6, 0x3A6, 0x05A.
  - active=1 for exactly those 4 cycles.
  - A paired decoder outputs decoded=0x5A at the following counter==0.
- Back-to-back 0x01 then 0xFF, in_valid held high:
  - in_ready deasserts while holding.
  - Consecutive frames carry 0x001/0x3FF pattern, then 0x0FF/0x301 pattern, with no IDLE frame between.
- Word accepted in the same cycle as fb: transmission starts one frame later, not this frame.
- Assert rst low at counter=2 during a frame:
  - chip_out=0 and active=0 immediately (asynchronous).
  - After release, nothing is transmitted until a new word is accepted.
- CDMA_ENC_STATS_EN defined:
  - 3 words sent back-to-back then a gap gives frames_sent=3 and underrun=1.
  - underrun stays 1 after further traffic.
